hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline hazard and sequencing controller for the 5-stage RV32 integer pipeline. It tracks the destination registers of the instructions in EX, MEM and WB in a private shadow pipeline. From that state it drives:
- the select lines of the 3-to-1 forwarding muxes (ALU operands in EX; branch comparator and JALR adder operands in ID);
- the PC-source 3-to-1 mux;
- PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush.

Branches (BEQ), JAL and JALR resolve in ID.

## Interface
- No parameters; register index width is fixed at 5, counter width at 16.
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs1, id_rs2  in  5 each  ID source register indices.
- id_use_rs1, id_use_rs2  in  1 each  instruction reads that operand.
- id_rd  in  5  ID destination register.
- id_regwrite, id_memread  in  1 each  ID writes rd / is LW.
- id_beq, id_jal, id_jalr  in  1 each  ID control-flow class.
- id_equal  in  1  ID comparator result.
- fwd_a, fwd_b  out  2 each  EX ALU operand mux select.
- fwd_c1, fwd_c2  out  2 each  ID comparator/JALR operand mux select.
- pc_sel  out  2  00 = PC+4, 01 = branch/JAL target, 10 = JALR target.
- pc_write, ifid_write  out  1 each  enables.
- idex_bubble  out  1  load a NOP into ID/EX.
- ifid_flush  out  1  zero IF/ID on next edge.
- stall_count  out  16  saturating count of stall cycles.

## Operation
- Forwarding select encoding for all four selects:
  - 00 = register file;
  - 01 = EX/MEM ALU result;
  - 10 = MEM/WB writeback value.
- Shadow state, one entry per stage:
  - EX entry: rd, rs1, rs2, regwrite, memread.
  - MEM entry: rd, regwrite, memread.
  - WB entry: rd, regwrite.
- Stage match definition: a stage "matches" register r when that stage has regwrite=1, rd≠0 and rd==r. Register x0 never matches.
- EX forwarding (fwd_a uses EX rs1, fwd_b uses EX rs2):
  - 01 if the MEM stage matches and MEM memread=0;
  - else 10 if the WB stage matches;
  - else 00.
  - MEM has priority over WB.
- ID forwarding (fwd_c1 uses id_rs1, fwd_c2 uses id_rs2): same rule, applied to id_rs1/id_rs2.
- Stall conditions (each gated by id_valid):
  - S1, load-use: EX memread=1, EX matches a used id_rs.
  - S2, ALU result to control flow: the instruction is beq or jalr, and the EX stage matches a used id_rs.
  - S3, load to control flow: the instruction is beq or jalr, MEM memread=1, and the MEM stage matches a used id_rs.
  - stall = S1 | S2 | S3.
- During a stall:
  - pc_write=0, ifid_write=0, idex_bubble=1;
  - pc_sel=00, ifid_flush=0.
- Redirect when not stalled, with id_valid=1:
  - jalr: pc_sel=10;
  - else jal, or beq with id_equal=1: pc_sel=01;
  - ifid_flush=1 whenever pc_sel≠00.
  - Priority: stall over redirect; jalr over jal over beq.
- Not-taken beq: pc_sel=00, no flush.
- Shadow update on each rising edge:
  - MEM→WB and EX→MEM always advance.
  - EX loads the ID fields if id_valid=1 and no stall; otherwise EX loads an invalid entry (regwrite=0, memread=0, rd=0).
- stall_count: increments on each stalled edge and saturates at 16'hFFFF.

## Timing
- All outputs except stall_count are combinational from the shadow state plus the current ID inputs, and are valid in the same cycle.
- Latency as seen by an ID instruction:
  - ALU→ALU dependency: 0 stalls, forwarded.
  - LW→ALU: 1 stall.
  - ALU→BEQ/JALR: 1 stall.
  - LW→BEQ/JALR: 2 stalls.
- Taken branch/jump: 1-cycle penalty via ifid_flush.
- Reset (async, reset_n=0), taking effect immediately:
  - all shadow entries invalid;
  - stall_count=0;
  - outputs: fwd_*=00, pc_sel=00, pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
- Reset asserted mid-stall discards in-flight state. The first cycle after release behaves like an empty pipeline.
- id_valid=0 gives no stall and no redirect, and inserts an invalid EX entry.

## Test plan
- Reset: assert reset_n=0 mid-run -> all outputs reach their reset values without a clock edge, and stall_count reads 0.
- ALU forwarding priority: add x5 followed by add x5, then add x6,x5,x5 -> fwd_a=fwd_b=01 (MEM wins over WB). With one NOP between the producer and the consumer -> 10.
- Load-use: lw x7 followed by add x8,x7,x1 -> exactly 1 cycle with idex_bubble=1, pc_write=0; then fwd_a=10; stall_count=1.
- LW→BEQ: lw x3 followed by beq x3,x4 -> 2 stall cycles; third cycle fwd_c1=10. With id_equal=1, pc_sel=01 and ifid_flush=1.
- JALR after ALU: addi x1 followed by jalr x1 -> 1 stall; next cycle fwd_c1=01, pc_sel=10, ifid_flush=1.
- x0 and saturation: lw x0 followed by add x2,x0,x0 -> no stall, fwd=00. With stall_count forced near 16'hFFFF, repeated load-use -> counter holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - RV32 5-stage hazard, forwarding and PC sequencing control
// Keeps a private EX/MEM/WB shadow of destination registers and derives all steering from it.
module hazard_control_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_beq,
  input  logic        id_jal,
  input  logic        id_jalr,
  input  logic        id_equal,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  fwd_c1,
  output logic [1:0]  fwd_c2,
  output logic [1:0]  pc_sel,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic [15:0] stall_count
);

  logic [4:0] ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic       ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite;
  logic       ex_hit, mem_hit, ctrl_flow, stall;

  function automatic logic stage_match(input logic rw, input logic [4:0] rd,
                                       input logic [4:0] r);
    return rw && (rd != 5'd0) && (rd == r);
  endfunction

  // A load sitting in MEM has no data yet, so it never feeds the 01 path.
  function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                         input logic m_rw, input logic m_mr,
                                         input logic [4:0] m_rd,
                                         input logic w_rw, input logic [4:0] w_rd);
    if (stage_match(m_rw, m_rd, r) && !m_mr) return 2'b01;
    if (stage_match(w_rw, w_rd, r))          return 2'b10;
    return 2'b00;
  endfunction

  assign fwd_a  = fwd_sel(ex_rs1, mem_regwrite, mem_memread, mem_rd, wb_regwrite, wb_rd);
  assign fwd_b  = fwd_sel(ex_rs2, mem_regwrite, mem_memread, mem_rd, wb_regwrite, wb_rd);
  assign fwd_c1 = fwd_sel(id_rs1, mem_regwrite, mem_memread, mem_rd, wb_regwrite, wb_rd);
  assign fwd_c2 = fwd_sel(id_rs2, mem_regwrite, mem_memread, mem_rd, wb_regwrite, wb_rd);

  assign ex_hit    = (id_use_rs1 && stage_match(ex_regwrite, ex_rd, id_rs1)) ||
                     (id_use_rs2 && stage_match(ex_regwrite, ex_rd, id_rs2));
  assign mem_hit   = (id_use_rs1 && stage_match(mem_regwrite, mem_rd, id_rs1)) ||
                     (id_use_rs2 && stage_match(mem_regwrite, mem_rd, id_rs2));
  assign ctrl_flow = id_beq || id_jalr;
  assign stall     = id_valid && ((ex_memread && ex_hit) ||
                                  (ctrl_flow && ex_hit) ||
                                  (ctrl_flow && mem_memread && mem_hit));

  always_comb begin
    pc_write    = !stall;
    ifid_write  = !stall;
    idex_bubble = stall;
    pc_sel      = 2'b00;
    // Reset gate keeps a jump sitting in ID from redirecting while reset is held.
    if (reset_n && id_valid && !stall) begin
      if (id_jalr)                        pc_sel = 2'b10;
      else if (id_jal || (id_beq && id_equal)) pc_sel = 2'b01;
    end
    ifid_flush = (pc_sel != 2'b00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_rd        <= 5'd0;
      ex_rs1       <= 5'd0;
      ex_rs2       <= 5'd0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_rd       <= 5'd0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      wb_rd        <= 5'd0;
      wb_regwrite  <= 1'b0;
      stall_count  <= 16'd0;
    end else begin
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      mem_memread  <= ex_memread;
      if (id_valid && !stall) begin
        ex_rd       <= id_rd;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
      end else begin
        ex_rd       <= 5'd0;
        ex_rs1      <= 5'd0;
        ex_rs2      <= 5'd0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
      end
      if (stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - table, corner-sequence and random checks of hazard_control_unit
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic        id_beq, id_jal, id_jalr, id_equal;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  fwd_a, fwd_b, fwd_c1, fwd_c2, pc_sel;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush;
  logic [15:0] stall_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_control_unit dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_beq(id_beq), .id_jal(id_jal), .id_jalr(id_jalr), .id_equal(id_equal),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c1(fwd_c1), .fwd_c2(fwd_c2), .pc_sel(pc_sel),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .stall_count(stall_count)
  );

  typedef struct packed {
    logic v; logic [4:0] rs1, rs2, rd;
    logic u1, u2, rw, mr, beq, jal, jalr, eq;
  } in_t;

  typedef struct packed {
    logic [1:0] fa, fb, fc1, fc2, pcs;
    logic pw, iw, bub, fl;
    logic [15:0] cnt;
  } out_t;

  typedef struct {
    string nm; bit rst; in_t i; out_t o;
  } vec_t;

  typedef struct {
    logic [4:0] rd, rs1, rs2; logic rw, mr;
  } stg_t;

  vec_t tbl[$];
  stg_t pipe[3];
  int   mcnt;

  function automatic in_t nop();
    return '0;
  endfunction

  function automatic in_t alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    in_t x = '0;
    x.v = 1; x.rd = rd; x.rs1 = a; x.rs2 = b; x.u1 = 1; x.u2 = 1; x.rw = 1;
    return x;
  endfunction

  function automatic in_t lw(input logic [4:0] rd, input logic [4:0] base);
    in_t x = '0;
    x.v = 1; x.rd = rd; x.rs1 = base; x.u1 = 1; x.rw = 1; x.mr = 1;
    return x;
  endfunction

  function automatic in_t beq(input logic [4:0] a, input logic [4:0] b, input logic eq);
    in_t x = '0;
    x.v = 1; x.rs1 = a; x.rs2 = b; x.u1 = 1; x.u2 = 1; x.beq = 1; x.eq = eq;
    return x;
  endfunction

  function automatic in_t jalr(input logic [4:0] a, input logic [4:0] rd);
    in_t x = '0;
    x.v = 1; x.rs1 = a; x.u1 = 1; x.rd = rd; x.rw = 1; x.jalr = 1;
    return x;
  endfunction

  function automatic out_t mk(input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] c1,
                              input logic [1:0] c2, input logic [1:0] pcs, input logic st,
                              input logic [15:0] cnt);
    out_t o;
    o.fa = fa; o.fb = fb; o.fc1 = c1; o.fc2 = c2; o.pcs = pcs;
    o.pw = !st; o.iw = !st; o.bub = st; o.fl = (pcs != 2'b00); o.cnt = cnt;
    return o;
  endfunction

  function automatic out_t dut_out();
    return {fwd_a, fwd_b, fwd_c1, fwd_c2, pc_sel, pc_write, ifid_write,
            idex_bubble, ifid_flush, stall_count};
  endfunction

  task automatic add_row(input string nm, input bit rst, input in_t i, input out_t o);
    vec_t r;
    r.nm = nm; r.rst = rst; r.i = i; r.o = o;
    tbl.push_back(r);
  endtask

  task automatic drive(input in_t x);
    id_valid = x.v; id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd;
    id_use_rs1 = x.u1; id_use_rs2 = x.u2; id_regwrite = x.rw; id_memread = x.mr;
    id_beq = x.beq; id_jal = x.jal; id_jalr = x.jalr; id_equal = x.eq;
  endtask

  task automatic chk(input string nm, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got fa=%0d fb=%0d c1=%0d c2=%0d pcs=%0d pw=%0b iw=%0b bub=%0b fl=%0b cnt=%h ; required fa=%0d fb=%0d c1=%0d c2=%0d pcs=%0d pw=%0b iw=%0b bub=%0b fl=%0b cnt=%h",
               nm, got.fa, got.fb, got.fc1, got.fc2, got.pcs, got.pw, got.iw, got.bub, got.fl, got.cnt,
               exp.fa, exp.fb, exp.fc1, exp.fc2, exp.pcs, exp.pw, exp.iw, exp.bub, exp.fl, exp.cnt);
    end
  endtask

  task automatic chk_val(input string nm, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(nop());
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reference model: stage list EX, MEM, WB evaluated directly from the hazard rules.
  function automatic bit hit(input stg_t s, input logic [4:0] r);
    return s.rw && (s.rd != 0) && (s.rd == r);
  endfunction

  function automatic logic [1:0] sel(input logic [4:0] r);
    if (hit(pipe[1], r) && !pipe[1].mr) return 2'd1;
    if (hit(pipe[2], r)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit uses(input stg_t s, input in_t x);
    return (x.u1 && hit(s, x.rs1)) || (x.u2 && hit(s, x.rs2));
  endfunction

  function automatic bit model_stall(input in_t x);
    bit cf = x.beq || x.jalr;
    if (!x.v) return 0;
    return (pipe[0].mr && uses(pipe[0], x)) || (cf && uses(pipe[0], x)) ||
           (cf && pipe[1].mr && uses(pipe[1], x));
  endfunction

  function automatic out_t model_out(input in_t x);
    bit st = model_stall(x);
    logic [1:0] pcs = 2'd0;
    if (x.v && !st) pcs = x.jalr ? 2'd2 : ((x.jal || (x.beq && x.eq)) ? 2'd1 : 2'd0);
    return mk(sel(pipe[0].rs1), sel(pipe[0].rs2), sel(x.rs1), sel(x.rs2), pcs, st, mcnt[15:0]);
  endfunction

  initial begin
    in_t x;
    out_t e;
    bit st;
    drive(nop());

    // Forwarding priority, MEM over WB.
    add_row("fwdA_c0", 1, alu(5, 1, 2), mk(0, 0, 0, 0, 0, 0, 0));
    add_row("fwdA_c1", 0, alu(5, 3, 4), mk(0, 0, 0, 0, 0, 0, 0));
    add_row("fwdA_c2", 0, alu(6, 5, 5), mk(0, 0, 1, 1, 0, 0, 0));
    add_row("fwdA_c3", 0, nop(),        mk(1, 1, 0, 0, 0, 0, 0));
    // One NOP between producer and consumer.
    add_row("fwdB_c0", 1, alu(5, 1, 2), mk(0, 0, 0, 0, 0, 0, 0));
    add_row("fwdB_c1", 0, nop(),        mk(0, 0, 0, 0, 0, 0, 0));
    add_row("fwdB_c2", 0, alu(6, 5, 5), mk(0, 0, 1, 1, 0, 0, 0));
    add_row("fwdB_c3", 0, nop(),        mk(2, 2, 0, 0, 0, 0, 0));
    // Load-use: one stall, then WB forward.
    add_row("ldu_c0", 1, lw(7, 1),      mk(0, 0, 0, 0, 0, 0, 0));
    add_row("ldu_c1", 0, alu(8, 7, 1),  mk(0, 0, 0, 0, 0, 1, 0));
    add_row("ldu_c2", 0, alu(8, 7, 1),  mk(0, 0, 0, 0, 0, 0, 1));
    add_row("ldu_c3", 0, nop(),         mk(2, 0, 0, 0, 0, 0, 1));
    // Load to branch: two stalls, then taken with WB forward.
    add_row("lwbeq_c0", 1, lw(3, 1),      mk(0, 0, 0, 0, 0, 0, 0));
    add_row("lwbeq_c1", 0, beq(3, 4, 1),  mk(0, 0, 0, 0, 0, 1, 0));
    add_row("lwbeq_c2", 0, beq(3, 4, 1),  mk(0, 0, 0, 0, 0, 1, 1));
    add_row("lwbeq_c3", 0, beq(3, 4, 1),  mk(0, 0, 2, 0, 1, 0, 2));
    add_row("lwbeq_c4", 0, nop(),         mk(0, 0, 0, 0, 0, 0, 2));
    // ALU to JALR: one stall, then MEM forward and redirect.
    add_row("jalr_c0", 1, alu(1, 2, 0),  mk(0, 0, 0, 0, 0, 0, 0));
    add_row("jalr_c1", 0, jalr(1, 6),    mk(0, 0, 0, 0, 0, 1, 0));
    add_row("jalr_c2", 0, jalr(1, 6),    mk(0, 0, 1, 0, 2, 0, 1));
    add_row("jalr_c3", 0, nop(),         mk(2, 0, 0, 0, 0, 0, 1));
    // x0 never creates a dependency.
    add_row("x0_c0", 1, lw(0, 1),        mk(0, 0, 0, 0, 0, 0, 0));
    add_row("x0_c1", 0, alu(2, 0, 0),    mk(0, 0, 0, 0, 0, 0, 0));
    add_row("x0_c2", 0, nop(),           mk(0, 0, 0, 0, 0, 0, 0));
    // Redirect priority and gating.
    x = beq(0, 0, 1); x.jal = 1; x.jalr = 1;
    add_row("prio_jalr", 1, x, mk(0, 0, 0, 0, 2, 0, 0));
    x = beq(0, 0, 0); x.jal = 1;
    add_row("prio_jal", 0, x, mk(0, 0, 0, 0, 1, 0, 0));
    add_row("beq_nt", 0, beq(0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
    x = nop(); x.jal = 1; x.jalr = 1;
    add_row("invalid_jump", 0, x, mk(0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      @(negedge clk);
      drive(tbl[k].i);
      #1 chk(tbl[k].nm, dut_out(), tbl[k].o);
    end

    // Asynchronous reset in the middle of a stall.
    do_reset();
    @(negedge clk); drive(lw(7, 1));
    @(negedge clk); drive(alu(8, 7, 1));
    @(negedge clk); drive(lw(7, 1));
    @(negedge clk); drive(alu(8, 7, 1));
    #1 chk("pre_reset_stall", dut_out(), mk(0, 0, 2, 0, 0, 1, 1));
    #1 id_jal = 1'b1; reset_n = 1'b0;
    #1 chk("async_reset", dut_out(), mk(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;
    drive(alu(8, 7, 1));
    #1 chk("post_reset_empty", dut_out(), mk(0, 0, 0, 0, 0, 0, 0));

    // Counter saturation from a preloaded value.
    do_reset();
    @(negedge clk);
    force dut.stall_count = 16'hFFFD;
    #1 release dut.stall_count;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive(lw(7, 1));
      #1 chk_val($sformatf("sat_cnt%0d", k), {1'b0, stall_count},
                 {1'b0, (k >= 2) ? 16'hFFFF : 16'hFFFD + 16'(k)});
      @(negedge clk); drive(alu(8, 7, 1));
      #1 chk_val($sformatf("sat_stall%0d", k), {idex_bubble, pc_write, 15'd0}, {1'b1, 1'b0, 15'd0});
    end
    @(negedge clk); drive(nop());
    #1 chk_val("sat_hold", {1'b0, stall_count}, {1'b0, 16'hFFFF});

    // Random traffic against the reference model.
    do_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '{default: '0};
    mcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      x.v = ($urandom_range(7) != 0);
      x.rs1 = 5'($urandom_range(3)); x.rs2 = 5'($urandom_range(3)); x.rd = 5'($urandom_range(3));
      x.u1 = 1'($urandom); x.u2 = 1'($urandom); x.rw = 1'($urandom);
      x.mr = ($urandom_range(2) == 0); x.beq = ($urandom_range(4) == 0);
      x.jal = ($urandom_range(7) == 0); x.jalr = ($urandom_range(5) == 0); x.eq = 1'($urandom);
      drive(x);
      #1;
      e = model_out(x);
      st = model_stall(x);
      chk($sformatf("rand%0d", n), dut_out(), e);
      @(posedge clk);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (x.v && !st) pipe[0] = '{rd: x.rd, rs1: x.rs1, rs2: x.rs2, rw: x.rw, mr: x.mr};
      else pipe[0] = '{default: '0};
      if (st && mcnt < 65535) mcnt++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
